// File: rtl/tpu_host_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_pkg
// Description : Shared default widths and FSM state encoding for the host
//               loader that fills activation SRAM and the weight FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

    localparam int c_ADDRESSSIZE  = 10;
    localparam int c_WORDSIZE     = 64;
    localparam int c_WEIGHT_BW    = 8;
    localparam int c_NUM_PE_ROWS  = 8;
    localparam int c_MATRIX_SIZE  = 8;
    localparam int c_DW           = c_WEIGHT_BW * c_NUM_PE_ROWS * c_MATRIX_SIZE;
    localparam int c_FIFO_DEPTH   = 4;

    localparam int c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE     = 3'd0;
    localparam state_t c_ST_LOAD_ACT = 3'd1;
    localparam state_t c_ST_LOAD_WGT = 3'd2;
    localparam state_t c_ST_WPUSH    = 3'd3;
    localparam state_t c_ST_START    = 3'd4;
    localparam state_t c_ST_LATCH    = 3'd5;
    localparam state_t c_ST_RUN      = 3'd6;

endpackage
`default_nettype wire

// File: rtl/tpu_host_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : tpu_host_loader_if
// Description : Command, input stream, SRAM write and weight FIFO signals of
//               the host loader. master = host/environment, slave = loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface tpu_host_loader_if #(
    parameter int ADDRESSSIZE = tpu_pkg::c_ADDRESSSIZE,
    parameter int WORDSIZE    = tpu_pkg::c_WORDSIZE,
    parameter int DW          = tpu_pkg::c_DW
) ();

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [ADDRESSSIZE-1:0] cmd_base;

    logic                   in_valid;
    logic                   in_ready;
    logic [WORDSIZE-1:0]    in_data;

    logic                   sram_write_enable;
    logic [ADDRESSSIZE-1:0] sram_address;
    logic [WORDSIZE-1:0]    sram_data_in;

    logic                   fifo_write_enable;
    logic [DW-1:0]          fifo_data_in;
    logic                   fifo_full;
    logic                   fifo_read_enable;

    modport master (
        output cmd_valid, cmd_base, in_valid, in_data, fifo_full,
        input  cmd_ready, in_ready, sram_write_enable, sram_address, sram_data_in,
        input  fifo_write_enable, fifo_data_in, fifo_read_enable
    );

    modport slave (
        input  cmd_valid, cmd_base, in_valid, in_data, fifo_full,
        output cmd_ready, in_ready, sram_write_enable, sram_address, sram_data_in,
        output fifo_write_enable, fifo_data_in, fifo_read_enable
    );

endinterface
`default_nettype wire

// File: rtl/tpu_host_loader_tile_packer.sv
`default_nettype none
// ============================================================================
// Module      : tpu_tile_packer
// Description : Assembles BEATS words into one wide weight tile; beat k lands
//               in bits [WORDSIZE*k +: WORDSIZE]. Clear discards a partial tile.
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_tile_packer #(
    parameter int WORDSIZE = 64,
    parameter int BEATS    = 8,
    parameter int IDX_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clear,
    input  logic                      i_wr_en,
    input  logic [IDX_W-1:0]          i_idx,
    input  logic [WORDSIZE-1:0]       i_beat,
    output logic [WORDSIZE*BEATS-1:0] o_tile
);

    logic [WORDSIZE*BEATS-1:0] r_tile;

    // Store each accepted beat into its slot; reset or clear empties the tile.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_tile <= '0;
        end else if (i_wr_en) begin
            r_tile[i_idx*WORDSIZE +: WORDSIZE] <= i_beat;
        end
    end

    assign o_tile = r_tile;

endmodule
`default_nettype wire

// File: rtl/tpu_host_loader.sv
`default_nettype none
// ============================================================================
// Module      : tpu_host_loader
// Description : Loads ACT_ROWS activation words into SRAM, packs FIFO_DEPTH
//               weight tiles into the weight FIFO, then sequences the array
//               through start, latch and run with a run-time watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_host_loader
    import tpu_pkg::*;
#(
    parameter int ADDRESSSIZE = c_ADDRESSSIZE,
    parameter int WORDSIZE    = c_WORDSIZE,
    parameter int WEIGHT_BW   = c_WEIGHT_BW,
    parameter int NUM_PE_ROWS = c_NUM_PE_ROWS,
    parameter int MATRIX_SIZE = c_MATRIX_SIZE,
    parameter int FIFO_DEPTH  = c_FIFO_DEPTH,
    parameter int ACT_ROWS    = 8,
    parameter int TIMEOUT     = 1024
) (
    input  logic               clk,
    input  logic               rst,
    tpu_host_loader_if.slave   bus,
    output logic               start,
    output logic               we_rl,
    output logic               addr_ctrl_en,
    output logic               valid_address,
    input  logic               end_,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int c_TILE_BITS = WEIGHT_BW * NUM_PE_ROWS * MATRIX_SIZE;
    localparam int c_BEATS     = c_TILE_BITS / WORDSIZE;
    localparam int c_IDX_W     = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_ROW_W     = $clog2(ACT_ROWS + 1);
    localparam int c_TILE_W    = $clog2(FIFO_DEPTH + 1);
    localparam int c_CYC_W     = $clog2(TIMEOUT + 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [ADDRESSSIZE-1:0] r_base;
    logic [c_ROW_W-1:0]     r_row;
    logic [c_IDX_W-1:0]     r_beat;
    logic [c_TILE_W-1:0]    r_tile;
    logic [c_CYC_W-1:0]     r_cyc;
    logic [c_TILE_BITS-1:0] w_tile;

    logic r_start, r_we_rl, r_addr_ctrl_en, r_fifo_rd, r_busy, r_done, r_error;

    logic w_cmd_take, w_act_beat, w_wgt_beat, w_push;
    logic w_last_row, w_last_beat, w_last_tile, w_timeout;

    assign w_cmd_take  = (r_state == c_ST_IDLE) && bus.cmd_valid;
    assign w_act_beat  = (r_state == c_ST_LOAD_ACT) && bus.in_valid;
    assign w_wgt_beat  = (r_state == c_ST_LOAD_WGT) && bus.in_valid && !bus.fifo_full;
    assign w_push      = (r_state == c_ST_WPUSH) && !bus.fifo_full;
    assign w_last_row  = (r_row == c_ROW_W'(ACT_ROWS - 1));
    assign w_last_beat = (r_beat == c_IDX_W'(c_BEATS - 1));
    assign w_last_tile = (r_tile == c_TILE_W'(FIFO_DEPTH - 1));
    assign w_timeout   = (r_cyc == c_CYC_W'(TIMEOUT - 1));

    // Handshake readiness and the zero-latency SRAM write path.
    assign bus.cmd_ready         = (r_state == c_ST_IDLE);
    assign bus.in_ready          = (r_state == c_ST_LOAD_ACT) ||
                                   ((r_state == c_ST_LOAD_WGT) && !bus.fifo_full);
    assign bus.sram_write_enable = w_act_beat;
    assign bus.sram_address      = w_act_beat ? (r_base + ADDRESSSIZE'(r_row)) : '0;
    assign bus.sram_data_in      = w_act_beat ? bus.in_data : '0;
    assign bus.fifo_write_enable = w_push;
    assign bus.fifo_data_in      = w_tile;
    assign bus.fifo_read_enable  = r_fifo_rd;

    assign start         = r_start;
    assign we_rl         = r_we_rl;
    assign addr_ctrl_en  = r_addr_ctrl_en;
    assign valid_address = 1'b0;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;

    tpu_tile_packer #(
        .WORDSIZE (WORDSIZE),
        .BEATS    (c_BEATS),
        .IDX_W    (c_IDX_W)
    ) u_packer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_cmd_take || w_push),
        .i_wr_en (w_wgt_beat),
        .i_idx   (r_beat),
        .i_beat  (bus.in_data),
        .o_tile  (w_tile)
    );

    // Next-state selection; end_ only matters while running.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:     if (bus.cmd_valid) w_next = c_ST_LOAD_ACT;
            c_ST_LOAD_ACT: if (w_act_beat && w_last_row) w_next = c_ST_LOAD_WGT;
            c_ST_LOAD_WGT: if (w_wgt_beat && w_last_beat) w_next = c_ST_WPUSH;
            c_ST_WPUSH:    if (w_push) w_next = w_last_tile ? c_ST_START : c_ST_LOAD_WGT;
            c_ST_START:    w_next = c_ST_LATCH;
            c_ST_LATCH:    w_next = c_ST_RUN;
            c_ST_RUN:      if (end_ || w_timeout) w_next = c_ST_IDLE;
            default:       w_next = c_ST_IDLE;
        endcase
    end

    // State, counters and registered control outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_base         <= '0;
            r_row          <= '0;
            r_beat         <= '0;
            r_tile         <= '0;
            r_cyc          <= '0;
            r_start        <= 1'b0;
            r_we_rl        <= 1'b0;
            r_addr_ctrl_en <= 1'b0;
            r_fifo_rd      <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_start        <= (w_next == c_ST_START);
            r_we_rl        <= (w_next == c_ST_LATCH);
            r_fifo_rd      <= (w_next == c_ST_START) || (w_next == c_ST_LATCH);
            r_addr_ctrl_en <= (w_next == c_ST_RUN);
            r_busy         <= (w_next != c_ST_IDLE);
            r_done         <= (r_state == c_ST_RUN) && end_;
            r_error        <= (r_state == c_ST_RUN) && !end_ && w_timeout;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_base <= bus.cmd_base;
                        r_row  <= '0;
                        r_beat <= '0;
                        r_tile <= '0;
                        r_cyc  <= '0;
                    end
                end
                c_ST_LOAD_ACT: if (w_act_beat) r_row <= r_row + 1'b1;
                c_ST_LOAD_WGT: if (w_wgt_beat) r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
                c_ST_WPUSH:    if (w_push) r_tile <= r_tile + 1'b1;
                c_ST_RUN:      r_cyc <= r_cyc + 1'b1;
                default:       ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tpu_host_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_tpu_host_loader
// Description : Directed/randomized self-checking bench for tpu_host_loader.
//               A second instance with TIMEOUT=16 shares the stimulus and is
//               used for the watchdog behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tpu_host_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic end_sig = 1'b0;
    always #5 clk = ~clk;

    tpu_host_loader_if #(.ADDRESSSIZE(10), .WORDSIZE(64), .DW(512)) bus ();
    tpu_host_loader_if #(.ADDRESSSIZE(10), .WORDSIZE(64), .DW(512)) bus_t ();

    assign bus_t.cmd_valid = bus.cmd_valid;
    assign bus_t.cmd_base  = bus.cmd_base;
    assign bus_t.in_valid  = bus.in_valid;
    assign bus_t.in_data   = bus.in_data;
    assign bus_t.fifo_full = bus.fifo_full;

    logic start, we_rl, ace, va, busy, done, error;
    logic start_t, we_rl_t, ace_t, va_t, busy_t, done_t, error_t;

    tpu_host_loader dut (
        .clk(clk), .rst(rst), .bus(bus), .start(start), .we_rl(we_rl),
        .addr_ctrl_en(ace), .valid_address(va), .end_(end_sig),
        .busy(busy), .done(done), .error(error)
    );

    tpu_host_loader #(.TIMEOUT(16)) dut_t (
        .clk(clk), .rst(rst), .bus(bus_t), .start(start_t), .we_rl(we_rl_t),
        .addr_ctrl_en(ace_t), .valid_address(va_t), .end_(end_sig),
        .busy(busy_t), .done(done_t), .error(error_t)
    );

    typedef struct {
        int          cyc;
        logic [9:0]  addr;
        logic [63:0] data;
    } sram_wr_t;

    sram_wr_t     obs_sram[$];
    logic [511:0] obs_tiles[$];
    logic [9:0]   exp_addr[$];
    logic [63:0]  exp_data[$];
    logic [511:0] exp_tiles[$];

    int n_vec = 0;
    int n_mis = 0;
    int cycnt = 0;

    always @(posedge clk) cycnt <= cycnt + 1;

    // Record every SRAM and FIFO write the main DUT performs.
    always @(negedge clk) begin
        if (bus.sram_write_enable === 1'b1)
            obs_sram.push_back('{cycnt, bus.sram_address, bus.sram_data_in});
        if (bus.fifo_write_enable === 1'b1)
            obs_tiles.push_back(bus.fifo_data_in);
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ":cmd_ready"}, bus.cmd_ready, 1);
        check({tag, ":in_ready"}, bus.in_ready, 0);
        check({tag, ":sram_we"}, bus.sram_write_enable, 0);
        check({tag, ":sram_addr"}, bus.sram_address, 0);
        check({tag, ":sram_data"}, bus.sram_data_in, 0);
        check({tag, ":fifo_we"}, bus.fifo_write_enable, 0);
        check({tag, ":fifo_data"}, bus.fifo_data_in, 0);
        check({tag, ":fifo_re"}, bus.fifo_read_enable, 0);
        check({tag, ":start"}, start, 0);
        check({tag, ":we_rl"}, we_rl, 0);
        check({tag, ":addr_ctrl_en"}, ace, 0);
        check({tag, ":valid_address"}, va, 0);
        check({tag, ":busy"}, busy, 0);
        check({tag, ":done"}, done, 0);
        check({tag, ":error"}, error, 0);
    endtask

    // Issue a command and stream n_beats beats (8 activations then weights).
    task automatic load_job(input logic [9:0] base, input int stall_tile, input bit gaps,
                            input int n_beats, input bit noisy, input bit seq_act);
        logic [63:0]  beats[40];
        logic [511:0] t;
        int idx, guard, stall_cnt;
        bit acc, stall;
        exp_addr.delete(); exp_data.delete(); exp_tiles.delete();
        obs_sram.delete(); obs_tiles.delete();
        for (int i = 0; i < 40; i++) beats[i] = {$urandom, $urandom};
        if (seq_act) for (int i = 0; i < 8; i++) beats[i] = 64'h5A00_0000_0000_0000 + 64'(i);
        for (int i = 0; i < 8; i++) begin
            exp_addr.push_back(10'((int'(base) + i) % 1024));
            exp_data.push_back(beats[i]);
        end
        for (int tt = 0; tt < 4; tt++) begin
            if (16 + 8 * tt <= n_beats) begin
                t = '0;
                for (int k = 0; k < 8; k++) t = t | (512'(beats[8 + 8 * tt + k]) << (64 * k));
                exp_tiles.push_back(t);
            end
        end
        @(posedge clk); #1;
        bus.cmd_base = base;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        check("cmd_ready_idle", bus.cmd_ready, 1);
        @(posedge clk); #1;
        if (noisy) bus.cmd_base = ~base; else bus.cmd_valid = 1'b0;
        idx = 0; guard = 0; stall_cnt = 0;
        while (idx < n_beats && guard < 400) begin
            stall = (stall_tile >= 0) && (idx == 16 + 8 * stall_tile) && (stall_cnt < 5);
            bus.fifo_full = stall;
            bus.in_data = beats[idx];
            bus.in_valid = (gaps && !stall) ? ($urandom_range(3) != 0) : 1'b1;
            @(negedge clk);
            if (stall) begin
                stall_cnt++;
                check("stall_fifo_we", bus.fifo_write_enable, 0);
                check("stall_in_ready", bus.in_ready, 0);
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            guard++;
        end
        check("load_within_budget", guard < 400, 1);
        bus.in_valid = 1'b0;
        bus.fifo_full = 1'b0;
        bus.cmd_valid = 1'b0;
    endtask

    // Follow start/latch/run; end_after=0 lets the job run without end_.
    task automatic run_phase(input int end_after);
        bit found;
        int last;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (start === 1'b1) begin found = 1'b1; break; end
        end
        check("start_seen", found, 1);
        if (!found) return;
        check("start:fifo_re", bus.fifo_read_enable, 1);
        check("start:we_rl", we_rl, 0);
        check("start:busy", busy, 1);
        @(negedge clk);
        check("latch:we_rl", we_rl, 1);
        check("latch:fifo_re", bus.fifo_read_enable, 1);
        check("latch:start", start, 0);
        last = (end_after > 0) ? end_after : 18;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            check($sformatf("run%0d:addr_ctrl_en", k), ace, 1);
            check($sformatf("run%0d:ctrl_idle", k), {start, we_rl, bus.fifo_read_enable, va, done}, 0);
            if (k <= 16) check($sformatf("run%0d:t_error", k), {ace_t, error_t}, 2'b10);
            else if (k == 17) check("timeout:error_busy", {error_t, busy_t}, 2'b10);
            else if (k == 18) check("timeout:error_pulse", error_t, 0);
        end
        if (end_after > 0) begin
            end_sig = 1'b1;
            @(negedge clk);
            end_sig = 1'b0;
            check("end:done", done, 1);
            check("end:busy", busy, 0);
            check("end:cmd_ready", bus.cmd_ready, 1);
            check("end:addr_ctrl_en", ace, 0);
            check("end:error", error, 0);
            @(negedge clk);
            check("end:done_pulse", done, 0);
        end
    endtask

    task automatic compare_job(input bit consecutive);
        check("sram_count", obs_sram.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < obs_sram.size(); i++) begin
            check($sformatf("sram_addr[%0d]", i), obs_sram[i].addr, exp_addr[i]);
            check($sformatf("sram_data[%0d]", i), obs_sram[i].data, exp_data[i]);
        end
        if (consecutive && obs_sram.size() >= 8)
            check("act_back_to_back", obs_sram[7].cyc - obs_sram[0].cyc, 7);
        check("tile_count", obs_tiles.size(), exp_tiles.size());
        for (int i = 0; i < exp_tiles.size() && i < obs_tiles.size(); i++)
            check($sformatf("tile[%0d]", i), obs_tiles[i], exp_tiles[i]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_base  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.fifo_full = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values("por");

        // Base 0, sequential activations back-to-back, FIFO full during tile 2.
        load_job(10'h000, 2, 1'b0, 40, 1'b0, 1'b1);
        run_phase(20);
        compare_job(1'b1);

        // Random base with gaps; cmd_valid and end_ held high while loading.
        end_sig = 1'b1;
        load_job(10'($urandom), -1, 1'b1, 40, 1'b1, 1'b0);
        end_sig = 1'b0;
        run_phase(5);
        compare_job(1'b0);

        // Wrapping base; never end, watchdog instance times out; reset mid-RUN.
        load_job(10'h3FE, -1, 1'b1, 40, 1'b0, 1'b0);
        run_phase(0);
        compare_job(1'b0);
        check("midrun:busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("rst_run");

        // Reset while weight beat 5 is being presented; partial tile discarded.
        load_job(10'h3FE, -1, 1'b0, 13, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data = {$urandom, $urandom};
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_reset_values("rst_wgt");
        compare_job(1'b0);

        // Full job after the aborted one must produce clean tiles.
        load_job(10'($urandom), -1, 1'b1, 40, 1'b0, 1'b0);
        run_phase(3);
        compare_job(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tpu_host_loader.md
TPU_HOST_LOADER -- requirements
Module: tpu_host_loader

Interface
REQ-001 SHALL have parameters: ADDRESSSIZE=10 (SRAM address width); WORDSIZE=64 (SRAM word and input beat width); WEIGHT_BW=8; NUM_PE_ROWS=8; MATRIX_SIZE=8; FIFO_DEPTH=4 (weight tiles per job); ACT_ROWS=8 (activation words per job); TIMEOUT=1024 (max RUN cycles).
REQ-002 SHALL have one clock; reset is synchronous and active-high: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-003 Command port: cmd_valid in 1; cmd_ready out 1; cmd_base in ADDRESSSIZE, first SRAM address for activations.
REQ-004 Input stream: in_valid in 1; in_ready out 1; in_data in WORDSIZE.
REQ-005 SRAM side: sram_write_enable out 1; sram_address out ADDRESSSIZE; sram_data_in out WORDSIZE.
REQ-006 Weight FIFO side: fifo_write_enable out 1; fifo_data_in out DW=WEIGHT_BW*NUM_PE_ROWS*MATRIX_SIZE (512); fifo_full in 1; fifo_read_enable out 1.
REQ-007 Array control: start out 1; we_rl out 1; addr_ctrl_en out 1; valid_address out 1 (held 0); end_ in 1.
REQ-008 Status: busy out 1; done out 1 (one-cycle pulse); error out 1 (one-cycle pulse on timeout).

Function
REQ-009 States SHALL be IDLE, LOAD_ACT, LOAD_WGT, WPUSH, START, LATCH, RUN.
REQ-010 IDLE: cmd_ready=1; cmd_valid -> latch cmd_base, clear counters, go to LOAD_ACT next cycle.
REQ-011 LOAD_ACT: in_ready=1; each accepted beat (in_valid&in_ready) SHALL drive sram_write_enable=1, sram_address=base+row, sram_data_in=in_data the same cycle (combinational from the beat, zero latency); row increments; after beat ACT_ROWS-1 go to LOAD_WGT.
REQ-012 SRAM address SHALL wrap modulo 2^ADDRESSSIZE.
REQ-013 LOAD_WGT: in_ready = !fifo_full; beat k (0..7) SHALL be stored into tile register bits [64k+63:64k]; after beat 7 go to WPUSH.
REQ-014 WPUSH: fifo_write_enable=1 for exactly one cycle with fifo_data_in = assembled tile, in_ready=0; when fifo_full=1, the write SHALL be held off (fifo_write_enable=0) until fifo_full=0; tile counter increments; if tile<FIFO_DEPTH return to LOAD_WGT, else go to START.
REQ-015 START: one cycle with start=1, fifo_read_enable=1.
REQ-016 LATCH: one cycle with we_rl=1, fifo_read_enable=1, start=0.
REQ-017 RUN: addr_ctrl_en=1, all other control 0; end_=1 -> done pulse, go to IDLE; cycle counter reaching TIMEOUT -> error pulse, go to IDLE.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 Stream beats with in_valid while in_ready=0 SHALL be ignored (not consumed); cmd_valid outside IDLE SHALL be ignored.
REQ-020 end_ asserted in any state other than RUN SHALL be ignored.

Reset
REQ-021 rst SHALL force IDLE within one cycle, including mid-load or mid-RUN; all counters, tile register and cmd_base cleared to 0.
REQ-022 Reset values: every 1-bit output 0 except cmd_ready=1 (follows IDLE after reset); sram_address=0; sram_data_in=0; fifo_data_in=0.
REQ-023 A partially assembled tile SHALL be discarded on reset; no partial FIFO write.

Structure
REQ-024 Shared package tpu_pkg SHALL hold the state encoding and the default widths (ADDRESSSIZE, WORDSIZE, DW, FIFO_DEPTH).
REQ-025 One sub-module, tpu_tile_packer (8x64-bit beats -> 512-bit tile with beat index and clear), SHALL be used for LOAD_WGT assembly.

Verification
REQ-026 cmd_base=0, 8 activation beats 0x..00..0x..07 back-to-back -> SRAM writes at addresses 0..7 in 8 consecutive cycles, data matched.
REQ-027 32 weight beats after activations, fifo_full=0 -> 4 fifo_write_enable pulses, each tile = concat of its 8 beats, beat 0 in bits [63:0].
REQ-028 fifo_full=1 held 5 cycles during WPUSH of tile 2 -> write delayed until fifo_full=0, in_ready=0 meanwhile, no beat lost.
REQ-029 After last tile -> start+fifo_read_enable one cycle, then we_rl+fifo_read_enable one cycle, then addr_ctrl_en=1; end_ after 20 cycles -> done pulse, IDLE.
REQ-030 end_ never asserted, TIMEOUT=16 -> error pulse after 16 RUN cycles, busy=0 next cycle.
REQ-031 rst during LOAD_WGT beat 5 and cmd_base=0x3FE with 8 rows -> outputs at reset values; separately, addresses 0x3FE,0x3FF,0x000..0x005 (wrap).
